// File: rtl/rca_wb_sequencer.sv
// -----------------------------------------------------------------------------
// rca_wb_sequencer
//
// Buffers one result bundle per RCA use instruction and serialises it onto the
// single register-file writeback port, one write per accepted beat. The final
// beat of every bundle carries wb_last so writeback can retire the id.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   in_valid/ready    bundle handshake (ready = FIFO not full, registered)
//   in_id             instruction id of the bundle
//   in_en             per-port result enable
//   in_rd             per-port destination register, 5 bits per port
//   in_data           per-port result, XLEN bits per port
//   wb_valid/ack      beat handshake
//   wb_we             beat writes the register file (0 for a null beat)
//   wb_rd, wb_data    destination and value of the beat
//   wb_id             id of the owning bundle
//   wb_last           final beat of the bundle
//   busy              FIFO holds at least one bundle
// -----------------------------------------------------------------------------
module rca_wb_sequencer #(
   parameter int XLEN            = 32,
   parameter int NUM_WRITE_PORTS = 4,
   parameter int ID_W            = 3,
   parameter int DEPTH           = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ID_W-1:0]                 in_id,
   input  logic [NUM_WRITE_PORTS-1:0]      in_en,
   input  logic [5*NUM_WRITE_PORTS-1:0]    in_rd,
   input  logic [XLEN*NUM_WRITE_PORTS-1:0] in_data,
   output logic                            wb_valid,
   input  logic                            wb_ack,
   output logic                            wb_we,
   output logic [4:0]                      wb_rd,
   output logic [XLEN-1:0]                 wb_data,
   output logic [ID_W-1:0]                 wb_id,
   output logic                            wb_last,
   output logic                            busy
);

   localparam int NWP    = NUM_WRITE_PORTS;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int PSEL_W = (NWP > 1) ? $clog2(NWP) : 1;

   // Port-indexed views of the flat input buses (same bit layout).
   logic [NWP-1:0][4:0]      in_rd_v;
   logic [NWP-1:0][XLEN-1:0] in_data_v;
   logic [NWP-1:0]           in_pend;

   assign in_rd_v   = in_rd;
   assign in_data_v = in_data;

   // A port is pending only if enabled and not targeting x0.
   always_comb begin
      in_pend = '0;
      for (int p = 0; p < NWP; p++) begin
         in_pend[p] = in_en[p] & (in_rd_v[p] != 5'd0);
      end
   end

   // ---------------------------------------------------------------------------
   // Bundle FIFO storage
   // ---------------------------------------------------------------------------
   logic [ID_W-1:0]          id_q   [DEPTH];
   logic [ID_W-1:0]          id_d   [DEPTH];
   logic [NWP-1:0][4:0]      rd_q   [DEPTH];
   logic [NWP-1:0][4:0]      rd_d   [DEPTH];
   logic [NWP-1:0][XLEN-1:0] data_q [DEPTH];
   logic [NWP-1:0][XLEN-1:0] data_d [DEPTH];
   logic [NWP-1:0]           pend_q [DEPTH];
   logic [NWP-1:0]           pend_d [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   // Last presented beat; drives wb_* while the FIFO is empty.
   logic            hold_we_q,   hold_we_d;
   logic [4:0]      hold_rd_q,   hold_rd_d;
   logic [XLEN-1:0] hold_data_q, hold_data_d;
   logic [ID_W-1:0] hold_id_q,   hold_id_d;
   logic            hold_last_q, hold_last_d;

   logic full;
   logic empty;
   logic push;
   logic ack;
   logic pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full;
   assign busy     = !empty;
   assign wb_valid = !empty;
   assign push     = in_valid & in_ready;

   // ---------------------------------------------------------------------------
   // Head beat selection: lowest-index pending port
   // ---------------------------------------------------------------------------
   logic [NWP-1:0]    head_pend;
   logic [PSEL_W-1:0] sel_p;
   logic              sel_found;
   logic              beat_we;
   logic [4:0]        beat_rd;
   logic [XLEN-1:0]   beat_data;
   logic              beat_last;

   assign head_pend = pend_q[rd_ptr_q];

   always_comb begin
      sel_p     = '0;
      sel_found = 1'b0;
      // Scan high to low so the lowest set bit wins.
      for (int p = NWP - 1; p >= 0; p--) begin
         if (head_pend[p]) begin
            sel_p     = PSEL_W'(p);
            sel_found = 1'b1;
         end
      end
   end

   // Null bundle (nothing pending) yields one beat with we=0, rd=0, data=0.
   assign beat_we   = sel_found;
   assign beat_rd   = sel_found ? rd_q[rd_ptr_q][sel_p]   : 5'd0;
   assign beat_data = sel_found ? data_q[rd_ptr_q][sel_p] : '0;
   // At most one pending bit left means this is the final beat.
   assign beat_last = ((head_pend & (head_pend - NWP'(1))) == '0);

   assign ack = wb_valid & wb_ack;
   assign pop = ack & beat_last;

   // Outputs follow the head beat while valid, otherwise keep the last beat.
   always_comb begin
      hold_we_d   = hold_we_q;
      hold_rd_d   = hold_rd_q;
      hold_data_d = hold_data_q;
      hold_id_d   = hold_id_q;
      hold_last_d = hold_last_q;
      if (wb_valid) begin
         hold_we_d   = beat_we;
         hold_rd_d   = beat_rd;
         hold_data_d = beat_data;
         hold_id_d   = id_q[rd_ptr_q];
         hold_last_d = beat_last;
      end
   end

   assign wb_we   = hold_we_d;
   assign wb_rd   = hold_rd_d;
   assign wb_data = hold_data_d;
   assign wb_id   = hold_id_d;
   assign wb_last = hold_last_d;

   // ---------------------------------------------------------------------------
   // FIFO next state
   // ---------------------------------------------------------------------------
   always_comb begin
      id_d     = id_q;
      rd_d     = rd_q;
      data_d   = data_q;
      pend_d   = pend_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      // Retire the served port; on the final beat the whole entry pops.
      if (ack && !beat_last) begin
         pend_d[rd_ptr_q][sel_p] = 1'b0;
      end

      // Push only happens when not full, so the tail never aliases a
      // non-empty head.
      if (push) begin
         id_d[wr_ptr_q]   = in_id;
         rd_d[wr_ptr_q]   = in_rd_v;
         data_d[wr_ptr_q] = in_data_v;
         pend_d[wr_ptr_q] = in_pend;
      end

      // DEPTH is a power of two, so pointers wrap naturally.
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            id_q[i]   <= '0;
            rd_q[i]   <= '0;
            data_q[i] <= '0;
            pend_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         hold_we_q   <= 1'b0;
         hold_rd_q   <= '0;
         hold_data_q <= '0;
         hold_id_q   <= '0;
         hold_last_q <= 1'b0;
      end else begin
         id_q        <= id_d;
         rd_q        <= rd_d;
         data_q      <= data_d;
         pend_q      <= pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         hold_we_q   <= hold_we_d;
         hold_rd_q   <= hold_rd_d;
         hold_data_q <= hold_data_d;
         hold_id_q   <= hold_id_d;
         hold_last_q <= hold_last_d;
      end
   end

endmodule

// File: tb/tb_rca_wb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rca_wb_sequencer
//
// Directed bench for rca_wb_sequencer. A queue-of-beats model expands each
// accepted bundle into its expected writeback beats; a per-cycle compare loop
// checks the DUT against it, and literal expectations on the logged beats pin
// the model to hand-computed results.
// -----------------------------------------------------------------------------
module tb_rca_wb_sequencer;

   localparam int XLEN  = 32;
   localparam int NWP   = 4;
   localparam int ID_W  = 3;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic            we;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic [ID_W-1:0] id;
      logic            last;
   } beat_t;

   logic                   clk;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [ID_W-1:0]        in_id;
   logic [NWP-1:0]         in_en;
   logic [5*NWP-1:0]       in_rd;
   logic [XLEN*NWP-1:0]    in_data;
   logic                   wb_valid;
   logic                   wb_ack;
   logic                   wb_we;
   logic [4:0]             wb_rd;
   logic [XLEN-1:0]        wb_data;
   logic [ID_W-1:0]        wb_id;
   logic                   wb_last;
   logic                   busy;

   rca_wb_sequencer #(
      .XLEN(XLEN), .NUM_WRITE_PORTS(NWP), .ID_W(ID_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
      .in_en(in_en), .in_rd(in_rd), .in_data(in_data),
      .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_id(wb_id), .wb_last(wb_last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------------------------------------------------------------------
   // Model: expected beat stream and number of buffered bundles
   // ---------------------------------------------------------------------------
   beat_t exp_q[$];
   int    nb;
   beat_t obs[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
         nb = 0;
      end else begin
         bit    acc;
         int    total;
         int    k;
         beat_t b;
         acc = in_valid && (nb < DEPTH);
         if (exp_q.size() > 0 && wb_ack) begin
            b = exp_q.pop_front();
            if (b.last) nb--;
         end
         if (acc) begin
            total = 0;
            for (int p = 0; p < NWP; p++)
               if (in_en[p] && in_rd[5*p +: 5] != 5'd0) total++;
            if (total == 0) begin
               b = '{we: 1'b0, rd: 5'd0, data: '0, id: in_id, last: 1'b1};
               exp_q.push_back(b);
            end else begin
               k = 0;
               for (int p = 0; p < NWP; p++) begin
                  if (in_en[p] && in_rd[5*p +: 5] != 5'd0) begin
                     b.we   = 1'b1;
                     b.rd   = in_rd[5*p +: 5];
                     b.data = in_data[XLEN*p +: XLEN];
                     b.id   = in_id;
                     b.last = (k == total - 1);
                     exp_q.push_back(b);
                     k++;
                  end
               end
            end
            nb++;
         end
      end
   end

   // Log of beats the DUT actually handed over.
   always @(posedge clk) begin
      if (rst && wb_valid && wb_ack)
         obs.push_back('{we: wb_we, rd: wb_rd, data: wb_data, id: wb_id, last: wb_last});
   end

   // ---------------------------------------------------------------------------
   // Check helpers
   // ---------------------------------------------------------------------------
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_obs(input string name, input int idx, input logic we,
                          input logic [4:0] rd, input logic [XLEN-1:0] data,
                          input logic [ID_W-1:0] id, input logic last);
      beat_t e;
      e = '{we: we, rd: rd, data: data, id: id, last: last};
      checks++;
      if (idx >= obs.size()) begin
         failures++;
         $display("FAIL %s: beat %0d missing (only %0d logged)", name, idx, obs.size());
      end else if (obs[idx] !== e) begin
         failures++;
         $display("FAIL %s: beat %0d got we=%0b rd=%0d data=%0h id=%0d last=%0b expected we=%0b rd=%0d data=%0h id=%0d last=%0b",
                  name, idx, obs[idx].we, obs[idx].rd, obs[idx].data, obs[idx].id, obs[idx].last,
                  we, rd, data, id, last);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   task automatic compare_loop();
      beat_t hold;
      beat_t cur;
      beat_t got;
      hold = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold = '0;
         end else begin
            chk("wb_valid", 64'(wb_valid), 64'(exp_q.size() > 0));
            chk("busy",     64'(busy),     64'(exp_q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(nb < DEPTH));
            cur = (exp_q.size() > 0) ? exp_q[0] : hold;
            got = '{we: wb_we, rd: wb_rd, data: wb_data, id: wb_id, last: wb_last};
            checks++;
            if (got !== cur) begin
               failures++;
               $display("FAIL beat: got we=%0b rd=%0d data=%0h id=%0d last=%0b expected we=%0b rd=%0d data=%0h id=%0d last=%0b",
                        got.we, got.rd, got.data, got.id, got.last,
                        cur.we, cur.rd, cur.data, cur.id, cur.last);
            end
            if (exp_q.size() > 0) hold = exp_q[0];
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic push_bundle(input logic [ID_W-1:0] id, input logic [NWP-1:0] en,
                              input logic [5*NWP-1:0] rd, input logic [XLEN*NWP-1:0] data);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_id    = id;
      in_en    = en;
      in_rd    = rd;
      in_data  = data;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL push_timeout: in_ready=%0b expected 1", in_ready);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(busy), 64'd0);
   endtask

   task automatic run_tests();
      int base;

      // Reset state
      #2;
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_busy",     64'(busy),     64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_wb_we",    64'(wb_we),    64'd0);
      chk("rst_wb_rd",    64'(wb_rd),    64'd0);
      chk("rst_wb_data",  64'(wb_data),  64'd0);
      chk("rst_wb_id",    64'(wb_id),    64'd0);
      chk("rst_wb_last",  64'(wb_last),  64'd0);
      #10 rst = 1'b1;

      // Bundle with a masked port
      wb_ack = 1'b1;
      base = obs.size();
      push_bundle(3'd2, 4'b1011, {5'd7, 5'd0, 5'd5, 5'd3},
                  {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      idle();
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      wait_idle("t1_drain");
      chk("t1_count", 64'(obs.size() - base), 64'd3);
      chk_obs("t1_b0", base + 0, 1'b1, 5'd3, 32'hA0, 3'd2, 1'b0);
      chk_obs("t1_b1", base + 1, 1'b1, 5'd5, 32'hA1, 3'd2, 1'b0);
      chk_obs("t1_b2", base + 2, 1'b1, 5'd7, 32'hA3, 3'd2, 1'b1);

      // Write to x0 only: null beat
      base = obs.size();
      push_bundle(3'd5, 4'b0001, {5'd1, 5'd1, 5'd1, 5'd0},
                  {32'h1, 32'h2, 32'h3, 32'hDEAD});
      idle();
      wait_idle("t2_drain");
      chk("t2_count", 64'(obs.size() - base), 64'd1);
      chk_obs("t2_b0", base, 1'b0, 5'd0, 32'h0, 3'd5, 1'b1);

      // Back-to-back bundles with writeback stalled
      wb_ack = 1'b0;
      base = obs.size();
      push_bundle(3'd1, 4'b0011, {5'd0, 5'd0, 5'd2, 5'd1}, {32'h0, 32'h0, 32'h11, 32'h10});
      push_bundle(3'd3, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h0, 32'h20});
      @(negedge clk);
      in_valid = 1'b1;
      in_id    = 3'd4;
      in_en    = 4'b0010;
      in_rd    = {5'd0, 5'd0, 5'd4, 5'd0};
      in_data  = {32'h0, 32'h0, 32'h30, 32'h0};
      chk("t3_full_ready", 64'(in_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk("t3_still_full", 64'(in_ready), 64'd0);
      wb_ack = 1'b1;
      begin
         int n;
         n = 0;
         while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("t3_ready_again", 64'(in_ready), 64'd1);
         chk("t3_popped_first", 64'(obs.size() - base), 64'd2);
      end
      @(posedge clk);
      idle();
      wait_idle("t3_drain");
      chk("t3_count", 64'(obs.size() - base), 64'd4);
      chk_obs("t3_b0", base + 0, 1'b1, 5'd1, 32'h10, 3'd1, 1'b0);
      chk_obs("t3_b1", base + 1, 1'b1, 5'd2, 32'h11, 3'd1, 1'b1);
      chk_obs("t3_b2", base + 2, 1'b1, 5'd3, 32'h20, 3'd3, 1'b1);
      chk_obs("t3_b3", base + 3, 1'b1, 5'd4, 32'h30, 3'd4, 1'b1);

      // Toggling ack over a 4-beat bundle
      wb_ack = 1'b0;
      base = obs.size();
      push_bundle(3'd6, 4'b1111, {5'd14, 5'd13, 5'd12, 5'd11},
                  {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      idle();
      begin
         int n;
         n = 0;
         wb_ack = 1'b1;
         while (busy && n < 40) begin
            @(negedge clk);
            wb_ack = ~wb_ack;
            n++;
         end
      end
      wb_ack = 1'b1;
      wait_idle("t4_drain");
      chk("t4_count", 64'(obs.size() - base), 64'd4);
      chk_obs("t4_b0", base + 0, 1'b1, 5'd11, 32'hC0, 3'd6, 1'b0);
      chk_obs("t4_b2", base + 2, 1'b1, 5'd13, 32'hC2, 3'd6, 1'b0);
      chk_obs("t4_b3", base + 3, 1'b1, 5'd14, 32'hC3, 3'd6, 1'b1);

      // Duplicate destination across ports
      base = obs.size();
      push_bundle(3'd7, 4'b0101, {5'd0, 5'd9, 5'd0, 5'd9},
                  {32'h0, 32'h22, 32'h0, 32'h11});
      idle();
      wait_idle("t5_drain");
      chk("t5_count", 64'(obs.size() - base), 64'd2);
      chk_obs("t5_b0", base + 0, 1'b1, 5'd9, 32'h11, 3'd7, 1'b0);
      chk_obs("t5_b1", base + 1, 1'b1, 5'd9, 32'h22, 3'd7, 1'b1);

      // Asynchronous reset in the middle of a bundle
      wb_ack = 1'b0;
      push_bundle(3'd3, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
                  {32'hD3, 32'hD2, 32'hD1, 32'hD0});
      idle();
      wb_ack = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t6_valid", 64'(wb_valid), 64'd0);
      chk("t6_busy",  64'(busy),     64'd0);
      chk("t6_ready", 64'(in_ready), 64'd1);
      base = obs.size();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_no_beat", 64'(obs.size() - base), 64'd0);
      chk("t6_idle_valid", 64'(wb_valid), 64'd0);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_id    = '0;
      in_en    = '0;
      in_rd    = '0;
      in_data  = '0;
      wb_ack   = 1'b0;
      fork
         compare_loop();
         run_tests();
      join_any
      disable fork;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
